// File: rtl/bcd_converter_seq.sv
// bcd_converter_seq: iterative shift-add-3 binary-to-BCD converter, one input bit per clock.
module bcd_converter_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]      sr_q, sr_d, sr_sh;
    logic [4*DIGITS-1:0]   scr_q, scr_d, scr_sh, adj, bcd_q, bcd_d;

    // Add-3 correction is applied to every digit before the shift.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign adj[4*d +: 4] = (scr_q[4*d +: 4] >= 4'd5) ? scr_q[4*d +: 4] + 4'd3 : scr_q[4*d +: 4];
    end

    assign {scr_sh, sr_sh} = {adj, sr_q} << 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = SHIFT;
                cnt_d   = '0;
                sr_d    = bin_in;
                scr_d   = '0;
            end
            SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                sr_d  = sr_sh;
                scr_d = scr_sh;
                if (cnt_q == LAST) begin
                    bcd_d   = scr_sh;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign bcd_out = bcd_q;
endmodule

// File: tb/tb_bcd_converter_seq.sv
// tb_bcd_converter_seq: directed checks of the 16-bit converter plus an 8-bit/3-digit instance.
module tb_bcd_converter_seq;
    logic        Clk = 0, Reset = 1;
    logic        start = 0, start8 = 0;
    logic [15:0] bin_in = 0;
    logic [7:0]  bin8 = 0;
    logic        busy, done, busy8, done8;
    logic [19:0] bcd_out;
    logic [11:0] bcd8;
    int checks = 0, errors = 0;
    int lat, bsy, ndone, t_prev, unstable;
    logic [19:0] held;
    logic [19:0] res [3];
    int tdone [3];

    always #5 Clk = ~Clk;

    bcd_converter_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out));

    bcd_converter_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
        .Clk(Clk), .Reset(Reset), .start(start8), .bin_in(bin8),
        .busy(busy8), .done(done8), .bcd_out(bcd8));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives a one-cycle start, then measures cycles to done and busy-high cycles.
    task automatic conv(input logic [15:0] v, output int l, output int b);
        @(negedge Clk); start = 1; bin_in = v;
        @(negedge Clk); start = 0; bin_in = ~v;
        l = 0; b = 0;
        while (!done && l < 60) begin
            if (busy) b++;
            @(negedge Clk); l++;
        end
        if (busy) b++;
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_bcd", {12'd0, bcd_out}, 0);
        Reset = 0;

        conv(16'h0000, lat, bsy);
        chk("zero_lat", lat, 16);
        chk("zero_bcd", {12'd0, bcd_out}, 32'h00000);
        chk("zero_busy", bsy, 17);
        @(negedge Clk);
        chk("zero_done_pulse", {31'd0, done}, 0);

        conv(16'hFFFF, lat, bsy);
        chk("ffff_bcd", {12'd0, bcd_out}, 32'h65535);
        chk("ffff_lat", lat, 16);
        conv(16'h04D2, lat, bsy);
        chk("04d2_bcd", {12'd0, bcd_out}, 32'h01234);
        conv(16'h270F, lat, bsy);
        chk("270f_bcd", {12'd0, bcd_out}, 32'h09999);

        // Restarts at cycle 5 and during DONE must be ignored.
        @(negedge Clk); start = 1; bin_in = 16'h0001;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (done) ndone++;
            start = (c == 5 || c == 16);
            bin_in = 16'h1234;
        end
        chk("ign_ndone", ndone, 1);
        chk("ign_bcd", {12'd0, bcd_out}, 32'h00001);
        chk("ign_busy", {31'd0, busy}, 0);

        // Reset mid-conversion discards the result.
        @(negedge Clk); start = 1; bin_in = 16'h3039;
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk); start = 0;
        end
        Reset = 1;
        @(negedge Clk);
        Reset = 0;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_bcd", {12'd0, bcd_out}, 0);
        chk("rst_done", {31'd0, done}, 0);
        ndone = 0;
        repeat (25) begin
            @(negedge Clk);
            if (done) ndone++;
        end
        chk("rst_no_done", ndone, 0);
        conv(16'h3039, lat, bsy);
        chk("rst_fresh_bcd", {12'd0, bcd_out}, 32'h12345);

        // Start held high; bin_in steps after each done.
        @(negedge Clk); start = 1; bin_in = 16'd100;
        ndone = 0; unstable = 0; held = bcd_out;
        for (int c = 0; c < 80 && ndone < 3; c++) begin
            @(negedge Clk);
            if (done) begin
                res[ndone] = bcd_out; tdone[ndone] = c; ndone++;
                bin_in = 16'd100 * 16'(ndone + 1);
                if (ndone == 3) start = 0;
            end else if (ndone > 0 && bcd_out !== held) unstable++;
            held = bcd_out;
        end
        chk("cont_ndone", ndone, 3);
        chk("cont_v0", {12'd0, res[0]}, 32'h00100);
        chk("cont_v1", {12'd0, res[1]}, 32'h00200);
        chk("cont_v2", {12'd0, res[2]}, 32'h00300);
        chk("cont_gap1", tdone[1] - tdone[0], 18);
        chk("cont_gap2", tdone[2] - tdone[1], 18);
        chk("cont_stable", unstable, 0);

        // 8-bit instance.
        @(negedge Clk); start8 = 1; bin8 = 8'hFF;
        @(negedge Clk); start8 = 0; bin8 = 8'h00;
        lat = 0;
        while (!done8 && lat < 40) begin
            @(negedge Clk); lat++;
        end
        chk("w8_lat", lat, 8);
        chk("w8_bcd", {20'd0, bcd8}, 32'h255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_converter_seq.md
# bcd_converter_seq

Sequential binary-to-BCD converter (iterative shift-add-3, one bit per clock) placed between the CPU result bus `CPU_out` and the seven-segment display drivers. Each 16-bit half of `CPU_out` gets its own instance, so the board shows the register value in decimal rather than hex. The block accepts a value on a start strobe, runs for a fixed number of cycles, then presents a stable packed-BCD word with a one-cycle done pulse. The display driver multiplexes that word.

## Interface
- `WIDTH`, default 16: binary input width.
- `DIGITS`, default 5: number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH − 1. This is not checked in RTL.
- `Clk`  in  1  system clock; all logic on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a conversion of `bin_in`. Sampled only in IDLE.
- `bin_in`  in  WIDTH  binary value, captured on the accepting edge.
- `busy`  out  1  high while the state is not IDLE.
- `done`  out  1  one-cycle pulse; `bcd_out` is new and valid in that cycle.
- `bcd_out`  out  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0]. Holds until the next `done`.

## Operation
- State machine with three states:
  - IDLE: if `start`, load `bin_in` into the shift register, clear the BCD scratch register, set bit counter = 0, go to SHIFT.
  - SHIFT: each cycle:
    - add 3 to every scratch digit ≥ 5;
    - shift {scratch, shift register} left by 1;
    - increment the counter.
    - On the shift where counter == WIDTH−1, load `bcd_out` with the post-shift scratch value and go to DONE.
  - DONE: `done` = 1 for exactly this cycle; next state IDLE unconditionally.
- `busy` = (state != IDLE). `done` = (state == DONE). Both are decoded from registered state, so they are glitch-free.
- Apply the add-3 correction to digit values before the shift. Scratch digits never exceed 9 after a shift.
- Counter width is clog2(WIDTH); WIDTH = 1 counts as a single shift.
- `start` while `busy` is high, including during the DONE cycle, is ignored. It is not queued.
- `bin_in` changing after acceptance has no effect on the running conversion.
- `bcd_out` changes only on the edge that enters DONE. In all other cycles it holds the previous result.
- Reset (any state, mid-conversion included): state = IDLE, counter = 0, scratch = 0, shift register = 0, `bcd_out` = 0, `busy` = 0, `done` = 0. A partial conversion is discarded and `bcd_out` does not update.
- Reset has priority over `start` on the same edge.

## Timing
- Reset values: `busy` 0, `done` 0, `bcd_out` 0.
- Edge numbering: edge E0 samples `start` = 1 in IDLE.
  - `busy` is high from after E0.
  - Shifts occur on E1 … E_WIDTH.
  - `bcd_out` is valid and `done` = 1 in the cycle after E_WIDTH.
  - IDLE again after E_WIDTH+1.
- Latency from start to `done` = WIDTH cycles. For WIDTH = 16, `done` rises 16 cycles after the accepting edge.
- With `start` held high continuously: a new conversion is accepted every WIDTH+2 cycles, with one IDLE cycle between each DONE and the next acceptance.
- No combinational path from any input to any output.

## Test plan
- Zero: Reset for 2 cycles, then `bin_in` = 0x0000 with a one-cycle `start`. Required: `done` exactly 16 cycles later, `bcd_out` = 0x00000, `busy` high for 17 cycles.
- Full scale: `bin_in` = 0xFFFF. Required: `bcd_out` = 0x65535. Also `bin_in` = 0x04D2 → 0x01234, and 0x270F → 0x09999.
- Ignored start: start 0x0001, pulse `start` again with 0x1234 at cycles 5 and 16 (the DONE cycle). Required: a single `done` with `bcd_out` = 0x00001, and no second conversion.
- Reset mid-operation: start 0x3039, assert `Reset` at cycle 8. Required: next cycle `busy` = 0, `bcd_out` = 0x00000, no `done` pulse. A fresh start of 0x3039 then yields 0x12345.
- Continuous start: `start` tied high, `bin_in` stepping 100, 200, 300 per acceptance. Required: `done` pulses every 18 cycles with `bcd_out` = 0x00100, 0x00200, 0x00300; `bcd_out` stable between pulses.
- Parameter sweep: WIDTH = 8, DIGITS = 3 with `bin_in` = 0xFF. Required: `bcd_out` = 0x255 and latency of 8 cycles.
